// File: rtl/frost32_cpu_pkg.sv
// rtl/frost32_cpu_pkg.sv - CPU-wide data-port access type and size enums.
package PkgFrost32Cpu;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

endpackage

// File: rtl/frost32_mem_arbiter_pkg.sv
// rtl/frost32_mem_arbiter_pkg.sv - arbiter state enum and byte-lane helpers.
package PkgFrost32MemArb;
    import PkgFrost32Cpu::*;

    localparam int MSB_POS__FROST32_MEM_ARB_STATE = 1;

    typedef enum logic [MSB_POS__FROST32_MEM_ARB_STATE:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StErr  = 2'd3
    } StateFrost32MemArb;

    // Pick the addressed lane out of a memory word and right-align it.
    function automatic logic [31:0] read_lane(input logic [31:0] d,
                                              input logic [1:0] a,
                                              input DataInoutAccessSize s);
        logic [31:0] r;
        r = d;
        case (s)
            Dias16:  r = {16'h0000, d[{a[1], 4'b0000} +: 16]};
            Dias8:   r = {24'h000000, d[{a, 3'b000} +: 8]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] write_lane(input logic [31:0] d,
                                               input DataInoutAccessSize s);
        logic [31:0] r;
        r = d;
        case (s)
            Dias16:  r = {2{d[15:0]}};
            Dias8:   r = {4{d[7:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frost32_rr_picker.sv
// rtl/frost32_rr_picker.sv - combinational round-robin picker, search starts after last_grant.
module frost32_rr_picker #(
    parameter int NUM_CHANNELS = 2,
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic [NUM_CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]        last_grant_i,
    output logic [IDX_W-1:0]        grant_o,
    output logic                    any_o
);

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int off = 1; off <= NUM_CHANNELS; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_CHANNELS;
            if (!any_o && req_i[IDX_W'(idx)]) begin
                any_o   = 1'b1;
                grant_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/frost32_mem_arbiter.sv
// rtl/frost32_mem_arbiter.sv - N-channel round-robin arbiter onto one 32-bit memory port.
// FROST32_MEM_ARB_ALIGN_CHECK_EN: misaligned 32/16-bit accesses complete with an error.
module frost32_mem_arbiter
    import PkgFrost32Cpu::*;
    import PkgFrost32MemArb::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CHANNELS-1:0]            in_req,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]            in_access_type,
    input  logic [NUM_CHANNELS*2-1:0]          in_access_size,
    output logic [NUM_CHANNELS-1:0]            out_done,
    output logic [NUM_CHANNELS-1:0]            out_err,
    output logic [DATA_WIDTH-1:0]              out_rdata,
    output logic                               out_busy,
    input  logic [DATA_WIDTH-1:0]              mem_data_in,
    input  logic                               mem_wait_for_mem,
    output logic [DATA_WIDTH-1:0]              mem_data_out,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_access_type,
    output logic [1:0]                         mem_access_size,
    output logic                               mem_req_mem_access
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    StateFrost32MemArb  state_q, state_d;
    logic [IDX_W-1:0]   grant_q, last_grant_q, pick;
    logic               any_req;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rd_fmt;
    DataInoutAccessType type_q;
    DataInoutAccessSize size_q;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    DataInoutAccessType    sel_type;
    DataInoutAccessSize    sel_size;
    logic                  sel_bad;
    logic                  grant_en, rd_done, finish;

    frost32_rr_picker #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_picker (
        .req_i        (in_req),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_o        (any_req)
    );

    assign sel_addr = in_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = in_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_type = DataInoutAccessType'(in_access_type[pick]);
    assign sel_size = DataInoutAccessSize'(in_access_size[int'(pick)*2 +: 2]);

    always_comb begin
        sel_bad = (sel_size == DiasBad);
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
        if (sel_size == Dias32 && sel_addr[1:0] != 2'b00) sel_bad = 1'b1;
        if (sel_size == Dias16 && sel_addr[0]) sel_bad = 1'b1;
`endif
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        rd_done  = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_en = 1'b1;
                    state_d  = sel_bad ? StErr : StReq;
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                if (!mem_wait_for_mem) begin
                    rd_done = 1'b1;
                    finish  = 1'b1;
                    state_d = StIdle;
                end
            end
            StErr: begin
                finish  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_fmt             = read_lane(mem_data_in, addr_q[1:0], size_q);
    assign out_rdata          = rd_done ? rd_fmt : rdata_q;
    assign out_done           = finish ? (NUM_CHANNELS'(1) << grant_q) : '0;
    assign out_err            = (state_q == StErr) ? (NUM_CHANNELS'(1) << grant_q) : '0;
    assign out_busy           = (state_q != StIdle);
    assign mem_req_mem_access = (state_q == StReq);
    assign mem_data_out       = wdata_q;
    assign mem_addr           = addr_q;
    assign mem_access_type    = type_q;
    assign mem_access_size    = size_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_CHANNELS - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            type_q       <= DiatRead;
            size_q       <= Dias32;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                grant_q <= pick;
                addr_q  <= sel_addr;
                wdata_q <= write_lane(sel_data, sel_size);
                type_q  <= sel_type;
                size_q  <= sel_size;
            end
            if (finish) last_grant_q <= grant_q;
            if (rd_done) rdata_q <= rd_fmt;
        end
    end

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// tb/tb_frost32_mem_arbiter.sv - directed bench with a transaction-level reference model.
module tb_frost32_mem_arbiter;

    localparam int N = 2;

    logic        clk;
    logic        rst_n;
    logic [N-1:0]    in_req;
    logic [N*32-1:0] in_addr;
    logic [N*32-1:0] in_data;
    logic [N-1:0]    in_access_type;
    logic [N*2-1:0]  in_access_size;
    logic [N-1:0]    out_done;
    logic [N-1:0]    out_err;
    logic [31:0]     out_rdata;
    logic            out_busy;
    logic [31:0]     mem_data_in;
    logic            mem_wait_for_mem;
    logic [31:0]     mem_data_out;
    logic [31:0]     mem_addr;
    logic            mem_access_type;
    logic [1:0]      mem_access_size;
    logic            mem_req_mem_access;

    frost32_mem_arbiter #(
        .NUM_CHANNELS (N),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_req             (in_req),
        .in_addr            (in_addr),
        .in_data            (in_data),
        .in_access_type     (in_access_type),
        .in_access_size     (in_access_size),
        .out_done           (out_done),
        .out_err            (out_err),
        .out_rdata          (out_rdata),
        .out_busy           (out_busy),
        .mem_data_in        (mem_data_in),
        .mem_wait_for_mem   (mem_wait_for_mem),
        .mem_data_out       (mem_data_out),
        .mem_addr           (mem_addr),
        .mem_access_type    (mem_access_type),
        .mem_access_size    (mem_access_size),
        .mem_req_mem_access (mem_req_mem_access)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    // Observations of the DUT, set by the compare process, read by directed checks.
    logic        done_flag = 1'b0;
    int          done_cyc = 0;
    logic [31:0] done_rdata = '0;
    logic        done_err = 1'b0;
    int          mr_cnt = 0;
    int          mr_cyc = 0;
    logic [31:0] mr_wdata = '0;
    int          grant_log[$];

    // Reference model: one outstanding transaction, tracked by its age in cycles.
    int          m_active = 0;
    int          m_ch = 0;
    int          m_age = 0;
    int          m_last = N - 1;
    logic        m_bad = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    int          m_size = 0;
    logic        m_type = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] md, input logic [31:0] a, input int s);
        int sh;
        if (s == 1) begin
            sh = 16 * int'((a >> 1) & 32'd1);
            return (md >> sh) & 32'h0000FFFF;
        end
        if (s == 2) begin
            sh = 8 * int'(a & 32'd3);
            return (md >> sh) & 32'h000000FF;
        end
        return md;
    endfunction

    function automatic logic [31:0] exp_write(input logic [31:0] d, input int s);
        if (s == 1) return (d & 32'h0000FFFF) * 32'h00010001;
        if (s == 2) return (d & 32'h000000FF) * 32'h01010101;
        return d;
    endfunction

    always @(negedge clk) begin : model
        logic [31:0] e_done, e_err, e_rdata;
        logic        e_busy, e_req, found;
        int          c;
        e_done  = '0;
        e_err   = '0;
        e_busy  = 1'b0;
        e_req   = 1'b0;
        e_rdata = m_rdata;
        found   = 1'b0;
        if (!rst_n) begin
            m_active = 0;
            m_last   = N - 1;
            m_rdata  = '0;
            e_rdata  = '0;
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_data_out, 32'h0);
            chk("rst_mem_attr", {29'b0, mem_access_type, mem_access_size}, 32'h0);
        end else if (m_active == 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && in_req[c]) begin
                    found = 1'b1;
                    m_ch  = c;
                end
            end
            if (found) begin
                m_active = 1;
                m_age    = 1;
                m_addr   = in_addr[m_ch*32 +: 32];
                m_wdata  = in_data[m_ch*32 +: 32];
                m_type   = in_access_type[m_ch];
                m_size   = int'(in_access_size[m_ch*2 +: 2]);
                m_bad    = (m_size == 3);
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
                if ((m_size == 0 && m_addr[1:0] != 2'b00) || (m_size == 1 && m_addr[0])) m_bad = 1'b1;
`endif
            end
        end else begin
            e_busy = 1'b1;
            if (m_bad) begin
                e_done   = 32'd1 << m_ch;
                e_err    = e_done;
                m_active = 0;
                m_last   = m_ch;
            end else if (m_age == 1) begin
                e_req = 1'b1;
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_data_out", mem_data_out, exp_write(m_wdata, m_size));
                chk("mem_attr", {29'b0, mem_access_type, mem_access_size}, {29'b0, m_type, 2'(m_size)});
                m_age = 2;
            end else if (!mem_wait_for_mem) begin
                e_done   = 32'd1 << m_ch;
                e_rdata  = exp_read(mem_data_in, m_addr, m_size);
                m_rdata  = e_rdata;
                m_active = 0;
                m_last   = m_ch;
            end
        end
        chk("busy", 32'(out_busy), 32'(e_busy));
        chk("mem_req", 32'(mem_req_mem_access), 32'(e_req));
        chk("done", 32'(out_done), e_done);
        chk("err", 32'(out_err), e_err);
        chk("rdata", out_rdata, e_rdata);

        if (out_done != '0) begin
            done_flag  = 1'b1;
            done_cyc   = cyc;
            done_rdata = out_rdata;
            done_err   = (out_err != '0);
            for (int k = 0; k < N; k++) if (out_done[k]) grant_log.push_back(k);
        end
        if (mem_req_mem_access) begin
            mr_cnt++;
            mr_cyc   = cyc;
            mr_wdata = mem_data_out;
        end
    end

    task automatic run(input int ch, input logic [31:0] a, input logic [31:0] d,
                       input logic t, input logic [1:0] s, input int stalls,
                       input logic [31:0] md);
        int o;
        logic ok;
        o = 1 - ch;
        @(posedge clk);
        #1;
        done_flag = 1'b0;
        mr_cnt    = 0;
        in_addr[ch*32 +: 32]     = a;
        in_data[ch*32 +: 32]     = d;
        in_access_type[ch]       = t;
        in_access_size[ch*2 +: 2] = s;
        in_addr[o*32 +: 32]      = ~a;
        in_data[o*32 +: 32]      = ~d;
        in_access_size[o*2 +: 2] = 2'd3;
        mem_data_in      = md;
        mem_wait_for_mem = 1'b0;
        in_req[ch]       = 1'b1;
        t0 = cyc;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_flag) begin
                ok = 1'b1;
                break;
            end
            mem_wait_for_mem = ((cyc - t0) >= 2) && ((cyc - t0) < 2 + stalls);
            in_addr[o*32 +: 32] = in_addr[o*32 +: 32] + 32'd4;
        end
        in_req[ch]       = 1'b0;
        mem_wait_for_mem = 1'b0;
        if (!ok) chk("txn_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        rst_n = 1'b0;
        in_req = '0;
        in_addr = '0;
        in_data = '0;
        in_access_type = '0;
        in_access_size = '0;
        mem_data_in = '0;
        mem_wait_for_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy", 32'(out_busy), 32'h0);
        chk("rst_rdata", out_rdata, 32'h0);

        run(0, 32'h100, 32'h0, 1'b0, 2'd0, 0, 32'hDEADBEEF);
        chk("r19_req_lat", 32'(mr_cyc - t0), 32'd1);
        chk("r19_done_lat", 32'(done_cyc - t0), 32'd2);
        chk("r19_rdata", done_rdata, 32'hDEADBEEF);
        chk("r19_err", 32'(done_err), 32'd0);

        run(1, 32'h103, 32'h0, 1'b0, 2'd2, 0, 32'h11223344);
        chk("r21_b8_rdata", done_rdata, 32'h00000011);
        run(0, 32'h102, 32'h0, 1'b0, 2'd1, 0, 32'h11223344);
        chk("h16_rdata", done_rdata, 32'h00001122);
        run(1, 32'h200, 32'h0000ABCD, 1'b1, 2'd1, 0, 32'h0);
        chk("r21_h16_wdata", mr_wdata, 32'hABCDABCD);
        run(0, 32'h204, 32'h12345678, 1'b1, 2'd2, 0, 32'h0);
        chk("b8_wdata", mr_wdata, 32'h78787878);

        run(1, 32'h300, 32'h0, 1'b0, 2'd0, 3, 32'h0BADF00D);
        chk("r22_done_lat", 32'(done_cyc - t0), 32'd5);
        chk("r22_req_lat", 32'(mr_cyc - t0), 32'd1);
        chk("r22_req_cnt", 32'(mr_cnt), 32'd1);

        run(0, 32'h102, 32'h0, 1'b0, 2'd0, 0, 32'hCAFEF00D);
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
        chk("r23_done_lat", 32'(done_cyc - t0), 32'd1);
        chk("r23_err", 32'(done_err), 32'd1);
        chk("r23_req_cnt", 32'(mr_cnt), 32'd0);
`else
        chk("r23_done_lat", 32'(done_cyc - t0), 32'd2);
        chk("r23_err", 32'(done_err), 32'd0);
        chk("r23_rdata", done_rdata, 32'hCAFEF00D);
`endif

        run(1, 32'h400, 32'h0, 1'b0, 2'd3, 0, 32'h0);
        chk("bad_done_lat", 32'(done_cyc - t0), 32'd1);
        chk("bad_err", 32'(done_err), 32'd1);
        chk("bad_req_cnt", 32'(mr_cnt), 32'd0);

        @(posedge clk);
        #1;
        done_flag = 1'b0;
        in_addr[31:0] = 32'h500;
        in_access_size[1:0] = 2'd0;
        in_access_type[0] = 1'b0;
        mem_wait_for_mem = 1'b1;
        in_req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_req = '0;
        #1;
        chk("r24_busy", 32'(out_busy), 32'd0);
        chk("r24_mem_req", 32'(mem_req_mem_access), 32'd0);
        chk("r24_done", 32'(out_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_wait_for_mem = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("r24_no_done", 32'(done_flag), 32'd0);

        grant_log.delete();
        in_addr[31:0]  = 32'h10;
        in_addr[63:32] = 32'h20;
        in_access_size = '0;
        in_access_type = '0;
        mem_data_in    = 32'h5A5A5A5A;
        in_req         = 2'b11;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (grant_log.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        in_req = '0;
        chk("r20_complete", 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++)
            chk("r20_grant", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFFFFFF, 32'(i % 2));

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frost32_mem_arbiter.md
FROST32_MEM_ARBITER -- requirements
Module: frost32_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, number of requesting ports (range 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; only the value 32 is supported.
REQ-004 SHALL have the following ports:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  in_req  in  NUM_CHANNELS  per-channel request, held until that channel's done.
  in_addr  in  NUM_CHANNELS*ADDR_WIDTH  per-channel byte address.
  in_data  in  NUM_CHANNELS*DATA_WIDTH  per-channel write data, right-aligned.
  in_access_type  in  NUM_CHANNELS  per-channel DataInoutAccessType (DiatRead/DiatWrite).
  in_access_size  in  NUM_CHANNELS*2  per-channel DataInoutAccessSize.
  out_done  out  NUM_CHANNELS  one-cycle completion pulse.
  out_err  out  NUM_CHANNELS  one-cycle error pulse, coincident with done.
  out_rdata  out  DATA_WIDTH  right-aligned, zero-extended read data, valid with done.
  out_busy  out  1  high in every state other than StIdle.
  mem_data_in  in  DATA_WIDTH  memory read data.
  mem_wait_for_mem  in  1  memory stall.
  mem_data_out  out  DATA_WIDTH  lane-replicated write data.
  mem_addr  out  ADDR_WIDTH  latched address.
  mem_access_type  out  1  latched type.
  mem_access_size  out  2  latched size.
  mem_req_mem_access  out  1  memory request strobe.

Function
REQ-005 SHALL implement FSM states StIdle, StReq, StWait, StErr.
REQ-006 StIdle: when any in_req bit is high, SHALL grant the lowest-index requester at or after (last_grant+1) mod NUM_CHANNELS.
REQ-006a On a grant, SHALL latch that channel's addr/data/type/size and go to StReq; if the request is bad, SHALL go to StErr instead.
REQ-007 A request SHALL be bad when its size is DiasBad, or when misaligned under REQ-016.
REQ-008 StReq: mem_req_mem_access SHALL be 1 for exactly this cycle; next state StWait.
REQ-009 StWait: SHALL hold while mem_wait_for_mem=1.
REQ-009a StWait, first cycle with mem_wait_for_mem=0: SHALL pulse out_done[grant], drive out_rdata, update last_grant, and return to StIdle.
REQ-010 StErr: SHALL pulse out_done[grant] and out_err[grant] together, update last_grant, and return to StIdle; no memory access occurs.
REQ-011 Minimum latency SHALL be request seen in StIdle at cycle 0, mem request at cycle 1, done at cycle 2; each stall cycle adds one cycle.
REQ-012 Read sizing: Dias16 SHALL return mem_data_in[addr[1]*16 +:16] zero-extended.
REQ-012a Read sizing: Dias8 SHALL return mem_data_in[addr[1:0]*8 +:8] zero-extended; Dias32 SHALL pass through.
REQ-013 Write steering: Dias16 SHALL replicate the low half into both halves; Dias8 SHALL replicate the low byte into all four lanes.
REQ-014 Requester rule: a channel whose in_req is still 1 in the cycle after its done pulse SHALL be treated as a new request; changes to in_* of non-granted channels SHALL have no effect.
REQ-015 out_rdata SHALL hold its last value outside done cycles; out_done and out_err SHALL be 0 outside their pulse cycles.

Reset
REQ-016a rst_n=0 SHALL asynchronously force StIdle, last_grant=NUM_CHANNELS-1, and all outputs to 0, including mem_req_mem_access, even mid-transaction.
REQ-016b An aborted transaction SHALL produce no done pulse.

Configuration
REQ-016 Macro FROST32_MEM_ARB_ALIGN_CHECK_EN:
  defined: Dias32 with addr[1:0]!=0, or Dias16 with addr[0]!=0, SHALL be a bad request (StErr).
  undefined: low address bits SHALL be ignored for alignment and such requests SHALL proceed normally with lane selection per REQ-012/013.

Structure
REQ-017 The state enum SHALL live in shared package PkgFrost32MemArb, which SHALL also define constant MSB_POS__FROST32_MEM_ARB_STATE.
REQ-017a DataInoutAccessType and DataInoutAccessSize SHALL be reused from PkgFrost32Cpu, not redefined.
REQ-018 Round-robin selection SHALL be a combinational sub-module frost32_rr_picker (inputs: req vector, last_grant; outputs: grant index, any).

Verification
REQ-019 Single read, ch0, Dias32, addr 0x100, mem_data_in 0xDEADBEEF, no stall -> mem_req at cycle 1, done[0] at cycle 2, out_rdata 0xDEADBEEF.
REQ-020 ch0 and ch1 both request continuously -> grants alternate 0,1,0,1; no channel granted twice in a row.
REQ-021 Dias8 read at addr 0x103, mem_data_in 0x11223344 -> out_rdata 0x00000011; Dias16 write of 0xABCD -> mem_data_out 0xABCDABCD.
REQ-022 mem_wait_for_mem held 1 for 3 cycles -> done occurs at cycle 5, mem_req high only in cycle 1.
REQ-023 With macro defined, Dias32 at addr 0x102 -> done+err at cycle 1, mem_req never asserted; without macro -> normal access.
REQ-024 rst_n pulsed low during StWait -> mem_req_mem_access and out_busy 0 immediately, no done pulse, next request granted normally.
